// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - display bus and capture result bundle for seven_seg_capture
//
// Signals:
//   seg          7-bit segment lines, bit0=a ... bit6=g
//   an           4-bit active-low anode selects, an[0]=digit0
//   bcd0..bcd3   captured digit values
//   digit_valid  per-digit "captured recently" flags
//   digit_blank  per-digit "last capture was all segments off"
//   digit_err    per-digit "last capture was undecodable"
//   frame_valid  one-cycle pulse when all four digits have been captured
// Modports:
//   master  drives the display bus and observes results (display driver / bench side)
//   slave   receives the display bus and produces results (capture block side)
interface seven_seg_capture_if;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic [3:0] digit_valid;
    logic [3:0] digit_blank;
    logic [3:0] digit_err;
    logic       frame_valid;

    modport master (
        output seg, an,
        input  bcd0, bcd1, bcd2, bcd3, digit_valid, digit_blank, digit_err, frame_valid
    );

    modport slave (
        input  seg, an,
        output bcd0, bcd1, bcd2, bcd3, digit_valid, digit_blank, digit_err, frame_valid
    );
endinterface

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - multiplexed 4-digit 7-segment bus receiver and BCD decoder
//
// Optional feature macro: SEVEN_SEG_HEX_DECODE_EN (also decode A-F patterns to 0xA-0xF).
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  seven_seg_capture_if.slave: seg/an in; bcd0..3, digit_valid, digit_blank,
//        digit_err, frame_valid out
// Parameters:
//   SETTLE_CYCLES   stable synchronized cycles required before a capture (>= 1)
//   TIMEOUT_CYCLES  cycles without capture before a digit's valid clears (>= 2)
//   SEG_ACTIVE_LOW  1: seg bit 0 lights a segment; 0: seg bit 1 lights it
module seven_seg_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_capture_if.slave  bus
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    logic [6:0]          seg_s1_q, seg_s2_q;
    logic [3:0]          an_s1_q, an_s2_q;
    logic [10:0]         s_prev_q, s_prev_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0][3:0]     bcd_q, bcd_d;
    logic [3:0]          valid_q, valid_d;
    logic [3:0]          blank_q, blank_d;
    logic [3:0]          err_q, err_d;
    logic [3:0]          seen_q, seen_d;
    logic                frame_q, frame_d;
    logic [3:0][TW-1:0]  tmo_q, tmo_d;

    logic [6:0]  pat;
    logic [10:0] samp;
    logic [3:0]  sel_n;
    logic        one_hot;
    logic [1:0]  sel_idx;
    logic        changed;
    logic        capture;
    logic [3:0]  dec_val;
    logic        dec_ok;
    logic        is_blank;
    logic [3:0]  seen_next;

    always_comb begin
        pat      = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
        samp     = {an_s2_q, pat};
        s_prev_d = samp;
        sel_n    = ~an_s2_q;
        one_hot  = $onehot(sel_n);
        changed  = (samp != s_prev_q);

        sel_idx = 2'd0;
        case (sel_n)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase

        is_blank = (pat == 7'h00);
        dec_ok   = 1'b1;
        dec_val  = 4'd0;
        case (pat)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
`ifdef SEVEN_SEG_HEX_DECODE_EN
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
`endif
            default: dec_ok = 1'b0;
        endcase

        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!one_hot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    // Ghosting or anode switch: restart the stability window.
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURED: begin
                if (!one_hot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        bcd_d     = bcd_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        tmo_d     = tmo_q;
        seen_next = '0;

        // Timeouts are applied first so that a capture in the same cycle overrides them.
        for (int i = 0; i < 4; i++) begin
            if (tmo_q[i] != TMO_LAST) begin
                tmo_d[i] = tmo_q[i] + 1'b1;
            end
            if (tmo_d[i] == TMO_LAST) begin
                valid_d[i] = 1'b0;
                seen_d[i]  = 1'b0;
            end
        end

        if (capture) begin
            valid_d[sel_idx] = 1'b1;
            tmo_d[sel_idx]   = '0;
            if (is_blank) begin
                blank_d[sel_idx] = 1'b1;
                err_d[sel_idx]   = 1'b0;
            end else if (dec_ok) begin
                bcd_d[sel_idx]   = dec_val;
                blank_d[sel_idx] = 1'b0;
                err_d[sel_idx]   = 1'b0;
            end else begin
                blank_d[sel_idx] = 1'b0;
                err_d[sel_idx]   = 1'b1;
            end
            seen_next          = seen_d;
            seen_next[sel_idx] = 1'b1;
            if (seen_next == 4'b1111) begin
                frame_d = 1'b1;
                seen_d  = 4'b0000;
            end else begin
                seen_d  = seen_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            an_s1_q  <= 4'hF;
            an_s2_q  <= 4'hF;
            s_prev_q <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bcd_q    <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            err_q    <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            seg_s1_q <= bus.seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= bus.an;
            an_s2_q  <= an_s1_q;
            s_prev_q <= s_prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.bcd0        = bcd_q[0];
    assign bus.bcd1        = bcd_q[1];
    assign bus.bcd2        = bcd_q[2];
    assign bus.bcd3        = bcd_q[3];
    assign bus.digit_valid = valid_q;
    assign bus.digit_blank = blank_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = frame_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    logic clk;
    logic rst;

    seven_seg_capture_if bus ();
    seven_seg_capture_if bus_t ();

    seven_seg_capture #(
        .SETTLE_CYCLES (16),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    seven_seg_capture #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(64),
        .SEG_ACTIVE_LOW(1)
    ) dut_t (
        .clk(clk),
        .rst(rst),
        .bus(bus_t.slave)
    );

    localparam logic [6:0] P1 = 7'h06;
    localparam logic [6:0] P2 = 7'h5B;
    localparam logic [6:0] P3 = 7'h4F;
    localparam logic [6:0] P4 = 7'h66;
    localparam logic [6:0] P5 = 7'h6D;
    localparam logic [6:0] P6 = 7'h7D;
    localparam logic [6:0] P7 = 7'h07;
    localparam logic [6:0] P8 = 7'h7F;
    localparam logic [6:0] P9 = 7'h6F;

    int checks;
    int failures;
    int frame_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) frame_cnt <= frame_cnt + 1;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] p, input int n);
        bus.an    = a;
        bus.seg   = ~p;
        bus_t.an  = a;
        bus_t.seg = ~p;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        hold(4'hF, 7'h00, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.bcd0 !== 4'd0 || bus.bcd1 !== 4'd0 || bus.bcd2 !== 4'd0 || bus.bcd3 !== 4'd0) begin
            failures++; $display("FAIL reset_bcd got=%h%h%h%h exp=0000", bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0); end
        checks++; if (bus.digit_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_valid got=%b exp=0000", bus.digit_valid); end
        checks++; if (bus.digit_blank !== 4'b0000 || bus.digit_err !== 4'b0000) begin
            failures++; $display("FAIL reset_blank_err got=%b/%b exp=0000/0000", bus.digit_blank, bus.digit_err); end
        checks++; if (bus.frame_valid !== 1'b0) begin
            failures++; $display("FAIL reset_frame got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_frame();
        int f0;
        f0 = frame_cnt;
        hold(4'b1110, P1, 40);
        hold(4'b1101, P2, 40);
        hold(4'b1011, P3, 40);
        checks++; if (frame_cnt !== f0) begin
            failures++; $display("FAIL frame_early got=%0d exp=%0d", frame_cnt, f0); end
        hold(4'b0111, P4, 40);
        checks++; if (bus.bcd0 !== 4'd1 || bus.bcd1 !== 4'd2 || bus.bcd2 !== 4'd3 || bus.bcd3 !== 4'd4) begin
            failures++; $display("FAIL frame_bcd got=%h%h%h%h exp=4321", bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0); end
        checks++; if (bus.digit_valid !== 4'b1111) begin
            failures++; $display("FAIL frame_valid_bits got=%b exp=1111", bus.digit_valid); end
        checks++; if (bus.digit_err !== 4'b0000 || bus.digit_blank !== 4'b0000) begin
            failures++; $display("FAIL frame_err_blank got=%b/%b exp=0000/0000", bus.digit_err, bus.digit_blank); end
        checks++; if (frame_cnt !== f0 + 1) begin
            failures++; $display("FAIL frame_pulse_count got=%0d exp=%0d", frame_cnt, f0 + 1); end
        hold(4'b1111, 7'h00, 10);
    endtask

    task automatic test_reset_mid_settle();
        hold(4'b1110, P9, 10);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.bcd1 !== 4'd0 || bus.digit_valid !== 4'b0000) begin
            failures++; $display("FAIL async_reset got=%h/%b exp=0/0000", bus.bcd1, bus.digit_valid); end
        @(negedge clk);
        rst = 1'b0;
        hold(4'b1111, 7'h00, 5);
    endtask

    task automatic test_short_pulse();
        hold(4'b1110, P7, 10);
        hold(4'b1111, 7'h00, 30);
        checks++; if (bus.bcd0 !== 4'd0) begin
            failures++; $display("FAIL short_bcd0 got=%h exp=0", bus.bcd0); end
        checks++; if (bus.digit_valid[0] !== 1'b0) begin
            failures++; $display("FAIL short_valid0 got=%b exp=0", bus.digit_valid[0]); end
    endtask

    task automatic test_multi_select();
        int f0;
        hold(4'b1110, P6, 40);
        f0 = frame_cnt;
        hold(4'b1100, P8, 100);
        checks++; if (bus.bcd0 !== 4'd6 || bus.bcd1 !== 4'd0) begin
            failures++; $display("FAIL multi_bcd got=%h/%h exp=6/0", bus.bcd0, bus.bcd1); end
        checks++; if (bus.digit_valid !== 4'b0001 || bus.digit_err !== 4'b0000 || bus.digit_blank !== 4'b0000) begin
            failures++; $display("FAIL multi_status got=%b/%b/%b exp=0001/0000/0000", bus.digit_valid, bus.digit_err, bus.digit_blank); end
        checks++; if (frame_cnt !== f0) begin
            failures++; $display("FAIL multi_frame got=%0d exp=%0d", frame_cnt, f0); end
    endtask

    task automatic test_err();
        hold(4'b1101, 7'h49, 40);
        checks++; if (bus.digit_err[1] !== 1'b1 || bus.bcd1 !== 4'd0 || bus.digit_valid[1] !== 1'b1) begin
            failures++; $display("FAIL err_set got err=%b bcd1=%h valid=%b exp err=1 bcd1=0 valid=1", bus.digit_err[1], bus.bcd1, bus.digit_valid[1]); end
        hold(4'b1101, P5, 40);
        checks++; if (bus.digit_err[1] !== 1'b0 || bus.bcd1 !== 4'd5) begin
            failures++; $display("FAIL err_clear got err=%b bcd1=%h exp err=0 bcd1=5", bus.digit_err[1], bus.bcd1); end
    endtask

    task automatic test_blank_and_ghost();
        int f0;
        hold(4'b1011, 7'h00, 40);
        checks++; if (bus.digit_blank[2] !== 1'b1 || bus.digit_err[2] !== 1'b0 || bus.bcd2 !== 4'd0 || bus.digit_valid[2] !== 1'b1) begin
            failures++; $display("FAIL blank_set got blank=%b err=%b bcd2=%h valid=%b exp 1/0/0/1", bus.digit_blank[2], bus.digit_err[2], bus.bcd2, bus.digit_valid[2]); end
        hold(4'b1011, P3, 40);
        checks++; if (bus.digit_blank[2] !== 1'b0 || bus.bcd2 !== 4'd3) begin
            failures++; $display("FAIL blank_clear got blank=%b bcd2=%h exp 0/3", bus.digit_blank[2], bus.bcd2); end
        f0 = frame_cnt;
        for (int k = 0; k < 10; k++) hold(4'b0111, (k % 2 == 0) ? P1 : P2, 8);
        checks++; if (bus.digit_valid[3] !== 1'b0 || bus.bcd3 !== 4'd0) begin
            failures++; $display("FAIL ghost_reject got valid3=%b bcd3=%h exp 0/0", bus.digit_valid[3], bus.bcd3); end
        hold(4'b0111, P4, 40);
        checks++; if (bus.bcd3 !== 4'd4 || bus.digit_valid !== 4'b1111) begin
            failures++; $display("FAIL ghost_settle got bcd3=%h valid=%b exp 4/1111", bus.bcd3, bus.digit_valid); end
        checks++; if (frame_cnt !== f0 + 1) begin
            failures++; $display("FAIL second_frame got=%0d exp=%0d", frame_cnt, f0 + 1); end
    endtask

    task automatic test_hex();
        hold(4'b0111, 7'h71, 40);
`ifdef SEVEN_SEG_HEX_DECODE_EN
        checks++; if (bus.bcd3 !== 4'hF || bus.digit_err[3] !== 1'b0) begin
            failures++; $display("FAIL hex_on got bcd3=%h err=%b exp F/0", bus.bcd3, bus.digit_err[3]); end
`else
        checks++; if (bus.bcd3 !== 4'd4 || bus.digit_err[3] !== 1'b1) begin
            failures++; $display("FAIL hex_off got bcd3=%h err=%b exp 4/1", bus.bcd3, bus.digit_err[3]); end
`endif
        checks++; if (bus.digit_valid[3] !== 1'b1) begin
            failures++; $display("FAIL hex_valid got=%b exp=1", bus.digit_valid[3]); end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        hold(4'b1011, P3, 0);
        k = 0;
        while (bus_t.digit_valid[2] !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++; if (bus_t.digit_valid[2] !== 1'b1 || bus_t.bcd2 !== 4'd3) begin
            failures++; $display("FAIL tmo_capture got valid2=%b bcd2=%h exp 1/3", bus_t.digit_valid[2], bus_t.bcd2); end
        k = 0;
        while (bus_t.digit_valid[2] === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 20) hold(4'b1110, P1, 0);
            if (k == 45) hold(4'b1111, 7'h00, 0);
        end
        checks++; if (k !== 63) begin
            failures++; $display("FAIL tmo_cycles got=%0d exp=63", k); end
        checks++; if (bus_t.digit_valid !== 4'b0001) begin
            failures++; $display("FAIL tmo_others got=%b exp=0001", bus_t.digit_valid); end
        checks++; if (bus_t.bcd2 !== 4'd3) begin
            failures++; $display("FAIL tmo_retain got=%h exp=3", bus_t.bcd2); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        frame_cnt = 0;
        rst       = 1'b1;
        bus.an    = 4'hF;
        bus.seg   = 7'h7F;
        bus_t.an  = 4'hF;
        bus_t.seg = 7'h7F;
        @(negedge clk);
        test_reset();
        test_frame();
        test_reset_mid_settle();
        test_short_pulse();
        test_multi_select();
        test_err();
        test_blank_and_ghost();
        test_hex();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
